// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter (inhibit, start, 8 data LSB first, odd parity, stop, ack); define PS2_HOST_TX_TIMEOUT_EN for the device-clock watchdog
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stb,
  input  logic       we,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       busy,
  input  logic       ps2ClkIn,
  input  logic       ps2DataIn,
  output logic       ps2ClkDriveLow,
  output logic       ps2DataDriveLow
);
  localparam int CW = $clog2(((INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES) + 1);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_INHIBIT = 2'd1;
  localparam logic [1:0] S_FRAME   = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          nack_q, nack_d;
  logic          tmo_q, tmo_d;
  logic          clk_dl_q, clk_dl_d;
  logic          dat_dl_q, dat_dl_d;
  logic [1:0]    clk_s_q, dat_s_q;
  logic          clk_prev_q, fall_q;
  logic          inh_done, rel;
  assign inh_done = cnt_q == CW'(INHIBIT_CYCLES - 1);
  assign rel      = (state_q == S_INHIBIT) && inh_done;
  assign busy            = state_q != S_IDLE;
  assign data_out        = {5'b0, tmo_q, nack_q, busy};
  assign ps2ClkDriveLow  = clk_dl_q;
  assign ps2DataDriveLow = dat_dl_q;
  // clock pin sync and falling-edge detect; forced idle-high when the host releases the clock so that release is never seen as an edge
  always_ff @(posedge clk) begin
    if (reset || rel) begin
      clk_s_q    <= 2'b11;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_s_q    <= {clk_s_q[0], ps2ClkIn};
      clk_prev_q <= clk_s_q[1];
      fall_q     <= clk_prev_q & ~clk_s_q[1];
    end
  end
  // data pin sync, used only for the device ack
  always_ff @(posedge clk)
    dat_s_q <= reset ? 2'b11 : {dat_s_q[0], ps2DataIn};
  // frame sequencer: accept, clock inhibit, then one action per recognised device falling edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    sh_d     = sh_q;
    par_d    = par_q;
    nack_d   = nack_q;
    tmo_d    = tmo_q;
    clk_dl_d = clk_dl_q;
    dat_dl_d = dat_dl_q;
    if (state_q == S_IDLE) begin
      if (stb && we) begin
        sh_d     = data_in;
        par_d    = ~^data_in;
        nack_d   = 1'b0;
        tmo_d    = 1'b0;
        cnt_d    = '0;
        bit_d    = 4'd0;
        clk_dl_d = 1'b1;
        dat_dl_d = 1'b0;
        state_d  = S_INHIBIT;
      end
    end else if (state_q == S_INHIBIT) begin
      cnt_d = inh_done ? '0 : cnt_q + 1'b1;
      if (inh_done) begin
        clk_dl_d = 1'b0;
        dat_dl_d = 1'b1;
        state_d  = S_FRAME;
      end
    end else if (fall_q) begin
      bit_d = bit_q + 1'b1;
      cnt_d = '0;
      dat_dl_d = (bit_q < 4'd8) ? ~sh_q[bit_q[2:0]] : (bit_q == 4'd8) ? ~par_q : 1'b0;
      if (bit_q == 4'd10) begin
        nack_d  = dat_s_q[1];
        state_d = S_IDLE;
      end
    end
`ifdef PS2_HOST_TX_TIMEOUT_EN
    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
      tmo_d    = 1'b1;
      clk_dl_d = 1'b0;
      dat_dl_d = 1'b0;
      state_d  = S_IDLE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
`else
`endif
  end
  // state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= 4'd0;
      sh_q     <= 8'd0;
      par_q    <= 1'b0;
      nack_q   <= 1'b0;
      tmo_q    <= 1'b0;
      clk_dl_q <= 1'b0;
      dat_dl_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      nack_q   <= nack_d;
      tmo_q    <= tmo_d;
      clk_dl_q <= clk_dl_d;
      dat_dl_q <= dat_dl_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: table-driven and random frames against a PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 20;
  localparam int TMO = 100;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       stb = 1'b0;
  logic       we = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       busy;
  logic       ps2ClkDriveLow, ps2DataDriveLow;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2ClkIn, ps2DataIn;
  int         n_checks = 0;
  int         n_fail = 0;
  typedef struct {
    logic [7:0] b;
    bit         ack;
    logic [7:0] st;
  } vec_t;
  vec_t vt[6];
  assign ps2ClkIn  = ~ps2ClkDriveLow & dev_clk;
  assign ps2DataIn = ~ps2DataDriveLow & dev_data;
  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .stb(stb), .we(we), .data_in(data_in),
    .data_out(data_out), .busy(busy), .ps2ClkIn(ps2ClkIn), .ps2DataIn(ps2DataIn),
    .ps2ClkDriveLow(ps2ClkDriveLow), .ps2DataDriveLow(ps2DataDriveLow)
  );
  always #5 clk = ~clk;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2) == 0;
    return {1'b1, par, b, 1'b0};
  endfunction
  task automatic do_reset;
    reset = 1'b1;
    dev_clk = 1'b1;
    dev_data = 1'b1;
    repeat (2) cyc;
    reset = 1'b0;
    cyc;
  endtask
  task automatic run_frame(input logic [7:0] b, input bit ack, input bit intrude,
                           input int rst_at, input int stop_at, input logic [7:0] exp_st);
    logic [10:0] bits;
    int inh;
    stb = 1'b1; we = 1'b1; data_in = b;
    cyc;
    stb = 1'b0; we = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_clkdl", ps2ClkDriveLow, 1);
    check("accept_status", data_out, 8'h01);
    inh = 1;
    for (int g = 0; g < 100000; g++) begin
      if (intrude && inh == 5) begin stb = 1'b1; we = 1'b1; data_in = 8'hFF; end
      cyc;
      stb = 1'b0; we = 1'b0;
      if (!ps2ClkDriveLow) break;
      inh++;
    end
    check("inhibit_len", inh, INH);
    check("start_bit_drive", ps2DataDriveLow, 1);
    repeat (5) cyc;
    bits = '0;
    bits[0] = ~ps2DataDriveLow;
    for (int k = 1; k <= 11; k++) begin
      dev_clk = 1'b0;
      if (intrude && k == 5) begin stb = 1'b1; we = 1'b1; data_in = 8'hFF; end
      if (k == 11) begin
        repeat (3) cyc;
        check("busy_hold", busy, 1);
        cyc;
        check("busy_drop", busy, 0);
        repeat (4) cyc;
      end else begin
        cyc;
        stb = 1'b0; we = 1'b0;
        repeat (7) cyc;
        bits[k] = ~ps2DataDriveLow;
      end
      if (k == rst_at) begin
        reset = 1'b1;
        cyc;
        reset = 1'b0;
        check("rst_mid_clkdl", ps2ClkDriveLow, 0);
        check("rst_mid_datdl", ps2DataDriveLow, 0);
        check("rst_mid_status", data_out, 8'h00);
        dev_clk = 1'b1;
        repeat (10) cyc;
        return;
      end
      dev_clk = 1'b1;
      if (k == 10 && ack) dev_data = 1'b0;
      repeat (8) cyc;
      if (k == stop_at) begin
        repeat (50) cyc;
        check("tmo_still_busy", busy, 1);
        repeat (60) cyc;
        check("tmo_status", data_out, 8'h04);
        check("tmo_clkdl", ps2ClkDriveLow, 0);
        check("tmo_datdl", ps2DataDriveLow, 0);
        return;
      end
    end
    dev_data = 1'b1;
    repeat (4) cyc;
    check("frame_bits", bits, frame_of(intrude ? 8'h00 : b));
    check("end_busy", busy, 0);
    check("end_status", data_out, exp_st);
    check("end_clkdl", ps2ClkDriveLow, 0);
    check("end_datdl", ps2DataDriveLow, 0);
  endtask
  initial begin
    vt[0] = '{8'hED, 1'b1, 8'h00};
    vt[1] = '{8'hF4, 1'b0, 8'h02};
    vt[2] = '{8'hFF, 1'b1, 8'h00};
    vt[3] = '{8'h00, 1'b0, 8'h02};
    vt[4] = '{8'h55, 1'b1, 8'h00};
    vt[5] = '{8'h80, 1'b0, 8'h02};
    do_reset;
    check("reset_status", data_out, 8'h00);
    check("reset_busy", busy, 0);
    check("reset_clkdl", ps2ClkDriveLow, 0);
    check("reset_datdl", ps2DataDriveLow, 0);
    stb = 1'b1; we = 1'b0; data_in = 8'hAA;
    cyc;
    stb = 1'b0;
    check("read_no_start", busy, 0);
    check("read_no_drive", ps2ClkDriveLow, 0);
    for (int i = 0; i < 6; i++) run_frame(vt[i].b, vt[i].ack, 1'b0, 0, 0, vt[i].st);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] b;
      bit a;
      b = 8'($urandom);
      a = 1'($urandom_range(1));
      run_frame(b, a, 1'b0, 0, 0, a ? 8'h00 : 8'h02);
    end
    run_frame(8'h00, 1'b1, 1'b1, 0, 0, 8'h00);
    run_frame(8'hC3, 1'b1, 1'b0, 5, 0, 8'h00);
    run_frame(8'hED, 1'b1, 1'b0, 0, 0, 8'h00);
    stb = 1'b1; we = 1'b1; data_in = 8'h01;
    cyc;
    stb = 1'b0; we = 1'b0;
    for (int g = 0; g < 1000 && ps2ClkDriveLow; g++) cyc;
    check("lat_released", ps2ClkDriveLow, 0);
    repeat (5) cyc;
    check("lat_start", ps2DataDriveLow, 1);
    dev_clk = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      cyc;
      check("lat_not_early", ps2DataDriveLow, 1);
    end
    cyc;
    check("lat_t4", ps2DataDriveLow, 0);
    repeat (4) cyc;
    do_reset;
    check("lat_reset_busy", busy, 0);
`ifdef PS2_HOST_TX_TIMEOUT_EN
    run_frame(8'hA5, 1'b1, 1'b0, 0, 4, 8'h00);
    run_frame(8'hF4, 1'b0, 1'b0, 0, 0, 8'h02);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the I-CPU to the keyboard, the opposite direction to the existing `kbd` PS/2 receiver. It sits on the I-CPU port bus beside `kbd` and `serback`, shares the keyboard's PS/2 clock and data lines, and drives them open-collector via drive-low enables. It runs the full PS/2 host frame: clock inhibit, start, 8 data bits LSB first, odd parity, stop, and device-ack sampling. A busy flag lets the receiver be gated during transmission.

## Interface
- `INHIBIT_CYCLES`, 5000: cycles the PS/2 clock is held low before the start bit (100 µs at 50 MHz).
- `TIMEOUT_CYCLES`, 750000: maximum cycles between device clock falling edges. Only used with `PS2_HOST_TX_TIMEOUT_EN`.
- `clk` in 1: system clock. Everything is on posedge.
- `reset` in 1: synchronous, active-high.
- `stb` in 1: bus access strobe, one cycle.
- `we` in 1: 1 = write (start a transmission), 0 = read status.
- `data_in` in 8: byte to transmit, sampled when `stb & we`.
- `data_out` out 8: status {5'b0, timeout, nack, busy}. Combinational from registers.
- `busy` out 1: high from accepted write until the frame ends.
- `ps2ClkIn` in 1: PS/2 clock pin, asynchronous.
- `ps2DataIn` in 1: PS/2 data pin, asynchronous.
- `ps2ClkDriveLow` out 1: 1 = pull the clock line low.
- `ps2DataDriveLow` out 1: 1 = pull the data line low.

## Operation
- **Input sync.** Each pin passes through 2 flops. A falling edge is sync'd previous = 1 and current = 0.
- **Write accept.** `stb & we` in IDLE latches `data_in` into the shift register. It also computes parity = ~^data_in, clears nack and timeout, and enters INHIBIT.
- **Ignored accesses.** A write while busy is ignored. Reads have no side effects.
- **States:**
  - IDLE: both drive-lows 0.
  - INHIBIT: `ps2ClkDriveLow` = 1; counter runs 0 to INHIBIT_CYCLES-1. On the last count, go to START with `ps2DataDriveLow` = 1 (start bit 0) and `ps2ClkDriveLow` = 0. The sync flops' previous value is forced to 1 so the host's own release is not seen as an edge.
  - START/DATA: on falling edges 1..8, drive data bit 0..7 (`ps2DataDriveLow` = ~bit). The bit counter is 4 bits and counts 1..11.
  - Edge 9: drive parity.
  - Edge 10: release data (stop bit 1).
  - Edge 11: sample sync'd data. 0 means ack; 1 sets `nack`. Then go to IDLE.
- **Frame length.** Exactly 11 device falling edges end a frame. There is no extra wait for the line to go idle.
- **Reset.** Clears state to IDLE, drive-lows 0, busy 0, status 0, counters 0. Reset mid-frame releases both lines on the next edge with no partial-frame completion.
- **busy.** `busy` = (state != IDLE).

## Timing
- **Accept.** The write in cycle N sets `busy` and `ps2ClkDriveLow` at edge N+1.
- **Clock release.** `ps2ClkDriveLow` is high for exactly INHIBIT_CYCLES cycles. It falls in the same cycle that `ps2DataDriveLow` rises.
- **Edge detection latency.** A pin falling edge is recognised 3 cycles later: 2 sync flops plus the detect compare. The data drive changes on the cycle after recognition.
- **Ack sample.** Data is sampled in the edge-11 recognition cycle. `busy` drops on the following edge.
- **Status.** `data_out` reflects new status in the cycle after any change. Errors stay set until the next accepted write.
- **Simultaneous events.** A write strobe coinciding with the edge-11 completion is ignored, because the state is still non-IDLE in that cycle.

## Configuration
- `PS2_HOST_TX_TIMEOUT_EN`:
  - Defined: a 20-bit watchdog reloads on entering START and on every recognised falling edge. When it reaches TIMEOUT_CYCLES, both lines are released, `timeout` is set, and the block returns to IDLE.
  - Undefined: there is no watchdog, the block waits indefinitely for device edges, and status bit 2 reads 0.

## Test plan
- **0xED with ack.** INHIBIT_CYCLES = 20 and a device model that acks. Write 0xED.
  - Clock held low for 20 cycles, then start 0.
  - Data bits 1,0,1,1,0,1,1,1, parity 1, stop released.
  - Ack low sampled, status 0x00 after completion, `busy` 0.
- **0xF4 with nack.** Write 0xF4. Expect data 0,0,1,0,1,1,1,1 and parity 0. The device leaves data high on edge 11, so status reads 0x02.
- **Write while busy.** Write 0x00 during INHIBIT, then write 0xFF mid-frame. Expect the 0x00 frame to be transmitted unchanged (parity 1) and the 0xFF write to have no effect.
- **Timeout (macro on).** TIMEOUT_CYCLES = 100; the device stops after 4 edges. After 100 idle cycles both drive-lows are 0 and status is 0x04. A following write of 0xF4 clears it to 0x01.
- **Reset mid-frame.** Assert `reset` after edge 5. On the next cycle both drive-lows are 0 and status is 0x00. A new write of 0xED then completes normally.
- **Sync latency.** Make a pin falling edge at cycle T. The data drive change is seen at cycle T+4 and never earlier.
